// File: rtl/pc_sequencer.sv
// pc_sequencer: control FSM that steers the program counter load interface.
//
// It decodes control-flow opcodes from the fetched instruction and resolves
// conditional branches against the ALU flags. It also keeps a return-address
// stack for CALL/RET, holds the PC while instruction memory stalls, and
// handles HALT/resume and stack faults.
//
// Ports
//   i_Clk          system clock, rising edge
//   i_Rst          synchronous reset, active-low
//   i_pc           current PC value
//   i_instr_valid  instruction memory output valid this cycle
//   i_instr_addr   address of the presented instruction
//   i_opcode       opcode of the presented instruction
//   i_target       branch/call target field
//   i_flag_z       ALU zero flag
//   i_flag_c       ALU carry flag
//   i_resume       level, leaves HALT
//   o_pc_load      PC load enable (hab_sal), combinational
//   o_pc_addr      PC load value (direc_sal), combinational
//   o_issue        presented non-control instruction accepted, combinational
//   o_flush        presented instruction squashed, combinational
//   o_halted       in HALT state, registered
//   o_fault        sticky stack overflow/underflow, registered
//   o_sp           return-stack occupancy, registered
module pc_sequencer #(
    parameter int AW        = 8,
    parameter int OPW       = 4,
    parameter int STK_DEPTH = 4
) (
    input  logic                           i_Clk,
    input  logic                           i_Rst,
    input  logic [AW-1:0]                  i_pc,
    input  logic                           i_instr_valid,
    input  logic [AW-1:0]                  i_instr_addr,
    input  logic [OPW-1:0]                 i_opcode,
    input  logic [AW-1:0]                  i_target,
    input  logic                           i_flag_z,
    input  logic                           i_flag_c,
    input  logic                           i_resume,
    output logic                           o_pc_load,
    output logic [AW-1:0]                  o_pc_addr,
    output logic                           o_issue,
    output logic                           o_flush,
    output logic                           o_halted,
    output logic                           o_fault,
    output logic [$clog2(STK_DEPTH):0]     o_sp
);

    localparam int IW  = $clog2(STK_DEPTH);
    localparam int SPW = IW + 1;

    localparam logic [OPW-1:0] OP_JMP  = OPW'(1);
    localparam logic [OPW-1:0] OP_JZ   = OPW'(2);
    localparam logic [OPW-1:0] OP_JNZ  = OPW'(3);
    localparam logic [OPW-1:0] OP_JC   = OPW'(4);
    localparam logic [OPW-1:0] OP_CALL = OPW'(5);
    localparam logic [OPW-1:0] OP_RET  = OPW'(6);
    localparam logic [OPW-1:0] OP_HALT = OPW'(7);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [SPW-1:0]  sp;
    logic [SPW-1:0]  sp_dec;
    logic [AW-1:0]   stk [STK_DEPTH];
    logic [AW-1:0]   stk_top;
    logic            fault_q;

    logic            run_dec;
    logic            is_ctrl;
    logic            cond_taken;
    logic            stk_full;
    logic            stk_empty;
    logic            call_ok;
    logic            ret_ok;
    logic            stk_err;
    logic            redirect;

    logic            do_push;
    logic            do_pop;
    logic            set_fault;

    logic            pc_load;
    logic [AW-1:0]   pc_addr;
    logic            issue;
    logic            flush;

    // Shared decode of the presented instruction
    assign sp_dec     = sp - SPW'(1);
    assign stk_top    = stk[sp_dec[IW-1:0]];
    assign stk_full   = (sp == SPW'(STK_DEPTH));
    assign stk_empty  = (sp == '0);
    assign run_dec    = (state == ST_RUN) && i_instr_valid;

    assign cond_taken = (i_opcode == OP_JMP)
                      | ((i_opcode == OP_JZ)  &  i_flag_z)
                      | ((i_opcode == OP_JNZ) & ~i_flag_z)
                      | ((i_opcode == OP_JC)  &  i_flag_c);
    assign call_ok    = (i_opcode == OP_CALL) & ~stk_full;
    assign ret_ok     = (i_opcode == OP_RET)  & ~stk_empty;
    // Stack errors take priority over the redirect the opcode would cause
    assign stk_err    = ((i_opcode == OP_CALL) & stk_full)
                      | ((i_opcode == OP_RET)  & stk_empty);
    assign is_ctrl    = (i_opcode >= OP_JMP) && (i_opcode <= OP_HALT);
    assign redirect   = run_dec & (cond_taken | call_ok | ret_ok);

    // State register and stack
    always_ff @(posedge i_Clk) begin
        if (!i_Rst) begin
            state   <= ST_RUN;
            sp      <= '0;
            fault_q <= 1'b0;
            for (int i = 0; i < STK_DEPTH; i++) begin
                stk[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            if (set_fault) begin
                fault_q <= 1'b1;
            end
            if (do_push) begin
                stk[sp[IW-1:0]] <= i_instr_addr + AW'(1);
                sp              <= sp + SPW'(1);
            end else if (do_pop) begin
                sp <= sp_dec;
            end
        end
    end

    // Next-state and stack control
    always_comb begin
        state_nxt = state;
        do_push   = 1'b0;
        do_pop    = 1'b0;
        set_fault = 1'b0;
        case (state)
            ST_RUN: begin
                if (i_instr_valid) begin
                    if (stk_err) begin
                        state_nxt = ST_FAULT;
                        set_fault = 1'b1;
                    end else if (cond_taken | call_ok | ret_ok) begin
                        state_nxt = ST_FLUSH;
                        do_push   = call_ok;
                        do_pop    = ret_ok;
                    end else if (i_opcode == OP_HALT) begin
                        state_nxt = ST_HALT;
                    end
                end
            end
            ST_FLUSH: state_nxt = ST_RUN;
            ST_HALT:  if (i_resume) state_nxt = ST_RUN;
            ST_FAULT: state_nxt = ST_FAULT;
            default:  state_nxt = ST_RUN;
        endcase
    end

    // PC steering outputs; a hold reloads the current PC to stop the increment
    always_comb begin
        pc_load = 1'b0;
        pc_addr = '0;
        issue   = 1'b0;
        flush   = 1'b0;
        case (state)
            ST_RUN: begin
                if (!i_instr_valid) begin
                    pc_load = 1'b1;
                    pc_addr = i_pc;
                end else if (redirect) begin
                    pc_load = 1'b1;
                    pc_addr = (i_opcode == OP_RET) ? stk_top : i_target;
                end else if (stk_err || (i_opcode == OP_HALT)) begin
                    pc_load = 1'b1;
                    pc_addr = i_pc;
                end else if (!is_ctrl) begin
                    issue = 1'b1;
                end
            end
            ST_FLUSH: flush = 1'b1;
            ST_HALT, ST_FAULT: begin
                pc_load = 1'b1;
                pc_addr = i_pc;
            end
            default: ;
        endcase
    end

    // Everything reads as zero while reset is asserted
    assign o_pc_load = i_Rst & pc_load;
    assign o_pc_addr = i_Rst ? pc_addr : '0;
    assign o_issue   = i_Rst & issue;
    assign o_flush   = i_Rst & flush;
    assign o_halted  = i_Rst & (state == ST_HALT);
    assign o_fault   = i_Rst & fault_q;
    assign o_sp      = i_Rst ? sp : '0;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    localparam int AW    = 8;
    localparam int OPW   = 4;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic       load;
        logic [7:0] addr;
        logic       issue;
        logic       flush;
        logic       halted;
        logic       fault;
        logic [2:0] sp;
    } obs_t;

    typedef struct packed {
        obs_t        exp;
        logic [31:0] ph;
    } sb_t;

    logic           i_Clk = 1'b0;
    logic           i_Rst = 1'b0;
    logic [AW-1:0]  i_pc = '0;
    logic           i_instr_valid = 1'b0;
    logic [AW-1:0]  i_instr_addr = '0;
    logic [OPW-1:0] i_opcode = '0;
    logic [AW-1:0]  i_target = '0;
    logic           i_flag_z = 1'b0;
    logic           i_flag_c = 1'b0;
    logic           i_resume = 1'b0;
    logic           o_pc_load;
    logic [AW-1:0]  o_pc_addr;
    logic           o_issue;
    logic           o_flush;
    logic           o_halted;
    logic           o_fault;
    logic [2:0]     o_sp;

    pc_sequencer #(.AW(AW), .OPW(OPW), .STK_DEPTH(DEPTH)) dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_pc(i_pc),
        .i_instr_valid(i_instr_valid), .i_instr_addr(i_instr_addr),
        .i_opcode(i_opcode), .i_target(i_target), .i_flag_z(i_flag_z),
        .i_flag_c(i_flag_c), .i_resume(i_resume), .o_pc_load(o_pc_load),
        .o_pc_addr(o_pc_addr), .o_issue(o_issue), .o_flush(o_flush),
        .o_halted(o_halted), .o_fault(o_fault), .o_sp(o_sp)
    );

    always #5 i_Clk = ~i_Clk;

    int  n_vec  = 0;
    int  n_miss = 0;
    sb_t sbq[$];

    // Reference model: program-level view of the sequencer
    bit       m_halted;
    bit       m_faulted;
    bit       m_squash_next;
    bit [7:0] m_ras[$];

    function automatic string ph_name(input int ph);
        case (ph)
            1: return "reset_run";
            2: return "cond_branch";
            3: return "call_ret";
            4: return "stack_fault";
            5: return "halt_resume";
            6: return "stall";
            default: return "random";
        endcase
    endfunction

    function automatic obs_t model_step(input bit rst, input bit vld, input bit [7:0] pc,
                                        input bit [7:0] addr, input bit [3:0] op,
                                        input bit [7:0] tgt, input bit z, input bit c,
                                        input bit res);
        obs_t e;
        e = '0;
        if (!rst) begin
            m_halted = 0; m_faulted = 0; m_squash_next = 0;
            m_ras.delete();
            return e;
        end
        e.halted = m_halted;
        e.fault  = m_faulted;
        e.sp     = 3'(m_ras.size());
        if (m_faulted) begin
            e.load = 1; e.addr = pc;
        end else if (m_squash_next) begin
            e.flush = 1; m_squash_next = 0;
        end else if (m_halted) begin
            e.load = 1; e.addr = pc;
            if (res) m_halted = 0;
        end else if (!vld) begin
            e.load = 1; e.addr = pc;
        end else begin
            bit       jump;
            bit [7:0] dest;
            jump = 0; dest = tgt;
            case (op)
                4'h1: jump = 1;
                4'h2: jump = z;
                4'h3: jump = !z;
                4'h4: jump = c;
                4'h5: begin
                    if (m_ras.size() == DEPTH) m_faulted = 1;
                    else begin m_ras.push_back(addr + 8'd1); jump = 1; end
                end
                4'h6: begin
                    if (m_ras.size() == 0) m_faulted = 1;
                    else begin dest = m_ras.pop_back(); jump = 1; end
                end
                4'h7: m_halted = 1;
                default: e.issue = 1;
            endcase
            if (jump) begin
                e.load = 1; e.addr = dest; m_squash_next = 1;
            end else if (m_faulted || m_halted) begin
                e.load = 1; e.addr = pc;
            end
        end
        return e;
    endfunction

    task automatic cyc(input bit rst, input bit vld, input bit [7:0] pc, input bit [7:0] addr,
                       input bit [3:0] op, input bit [7:0] tgt, input bit z, input bit c,
                       input bit res, input int ph);
        sb_t s;
        @(posedge i_Clk);
        #1;
        i_Rst = rst; i_instr_valid = vld; i_pc = pc; i_instr_addr = addr;
        i_opcode = op; i_target = tgt; i_flag_z = z; i_flag_c = c; i_resume = res;
        s.exp = model_step(rst, vld, pc, addr, op, tgt, z, c, res);
        s.ph  = 32'(ph);
        sbq.push_back(s);
    endtask

    // Monitor: compares each presented output against the queued expectation
    always @(negedge i_Clk) begin
        if (sbq.size() > 0) begin
            sb_t  s;
            obs_t got;
            obs_t e;
            s   = sbq.pop_front();
            e   = s.exp;
            got = '{load: o_pc_load, addr: o_pc_addr, issue: o_issue, flush: o_flush,
                    halted: o_halted, fault: o_fault, sp: o_sp};
            if (!e.load) begin
                got.addr = '0;
                e.addr   = '0;
            end
            n_vec++;
            if (got !== e) begin
                n_miss++;
                $display("FAIL %s vec=%0d got load=%0d addr=%02h issue=%0d flush=%0d halted=%0d fault=%0d sp=%0d required load=%0d addr=%02h issue=%0d flush=%0d halted=%0d fault=%0d sp=%0d",
                         ph_name(int'(s.ph)), n_vec, got.load, got.addr, got.issue, got.flush,
                         got.halted, got.fault, got.sp, e.load, e.addr, e.issue, e.flush,
                         e.halted, e.fault, e.sp);
            end
        end
    end

    initial begin
        // reset, straight-line execution, reset mid-run
        cyc(0, 1, 8'h00, 8'h00, 4'h1, 8'h55, 0, 0, 0, 1);
        cyc(0, 1, 8'h00, 8'h00, 4'h0, 8'h00, 0, 0, 0, 1);
        for (int a = 0; a < 3; a++) cyc(1, 1, 8'(a + 1), 8'(a), 4'h0, 8'h00, 0, 0, 0, 1);
        cyc(0, 1, 8'h04, 8'h03, 4'h5, 8'h66, 0, 0, 1, 1);
        cyc(1, 1, 8'h00, 8'h00, 4'h0, 8'h00, 0, 0, 0, 1);

        // JZ taken then not taken
        cyc(1, 1, 8'h11, 8'h10, 4'h2, 8'h40, 1, 0, 0, 2);
        cyc(1, 1, 8'h40, 8'h11, 4'h0, 8'h00, 1, 0, 0, 2);
        cyc(1, 1, 8'h41, 8'h40, 4'h0, 8'h00, 1, 0, 0, 2);
        cyc(1, 1, 8'h11, 8'h10, 4'h2, 8'h40, 0, 0, 0, 2);
        cyc(1, 1, 8'h12, 8'h11, 4'h0, 8'h00, 0, 0, 0, 2);
        cyc(1, 1, 8'h13, 8'h12, 4'h3, 8'h50, 0, 0, 0, 2);
        cyc(1, 1, 8'h50, 8'h13, 4'h0, 8'h00, 0, 0, 0, 2);
        cyc(1, 1, 8'h51, 8'h50, 4'h4, 8'h60, 1, 1, 0, 2);
        cyc(1, 1, 8'h60, 8'h51, 4'h0, 8'h00, 1, 1, 0, 2);

        // CALL/RET including wrap at 0xFF
        cyc(1, 1, 8'h21, 8'h20, 4'h5, 8'h80, 0, 0, 0, 3);
        cyc(1, 1, 8'h80, 8'h21, 4'h0, 8'h00, 0, 0, 0, 3);
        cyc(1, 1, 8'h86, 8'h85, 4'h6, 8'hAA, 0, 0, 0, 3);
        cyc(1, 1, 8'h21, 8'h86, 4'h0, 8'h00, 0, 0, 0, 3);
        cyc(1, 1, 8'h00, 8'hFF, 4'h5, 8'h10, 0, 0, 0, 3);
        cyc(1, 1, 8'h10, 8'h00, 4'h0, 8'h00, 0, 0, 0, 3);
        cyc(1, 1, 8'h15, 8'h14, 4'h6, 8'h77, 0, 0, 0, 3);
        cyc(1, 1, 8'h00, 8'h15, 4'h0, 8'h00, 0, 0, 0, 3);
        cyc(1, 1, 8'h01, 8'h00, 4'h0, 8'h00, 0, 0, 0, 3);

        // overflow on the fifth nested CALL, then underflow
        for (int k = 0; k < 5; k++) begin
            cyc(1, 1, 8'(8'h31 + 16 * k), 8'(8'h30 + 16 * k), 4'h5, 8'(8'h40 + 16 * k), 0, 0, 0, 4);
            if (k < 4) cyc(1, 1, 8'(8'h40 + 16 * k), 8'h00, 4'h0, 8'h00, 0, 0, 0, 4);
        end
        for (int k = 0; k < 4; k++) cyc(1, 1, 8'h71, 8'h70, 4'(k + 5), 8'h99, 0, 1, 1, 4);
        cyc(0, 1, 8'h00, 8'h00, 4'h0, 8'h00, 0, 0, 0, 4);
        cyc(1, 1, 8'h09, 8'h08, 4'h6, 8'h33, 0, 0, 0, 4);
        for (int k = 0; k < 3; k++) cyc(1, 1, 8'h09, 8'h08, 4'h0, 8'h00, 0, 0, 1, 4);
        cyc(0, 1, 8'h00, 8'h00, 4'h0, 8'h00, 0, 0, 0, 4);

        // HALT and resume
        cyc(1, 1, 8'h31, 8'h30, 4'h7, 8'h00, 0, 0, 0, 5);
        for (int k = 0; k < 10; k++) cyc(1, 1, 8'h31, 8'h30, 4'($urandom_range(0, 15)), 8'h00, 0, 0, 0, 5);
        cyc(1, 1, 8'h31, 8'h30, 4'h0, 8'h00, 0, 0, 1, 5);
        cyc(1, 1, 8'h32, 8'h31, 4'h0, 8'h00, 0, 0, 0, 5);

        // memory stall, and a stall during FLUSH
        for (int k = 0; k < 3; k++) cyc(1, 0, 8'h32, 8'h31, 4'h1, 8'hEE, 0, 0, 0, 6);
        cyc(1, 1, 8'h33, 8'h32, 4'h1, 8'h90, 0, 0, 0, 6);
        cyc(1, 0, 8'h90, 8'h33, 4'h0, 8'h00, 0, 0, 0, 6);
        cyc(1, 1, 8'h91, 8'h90, 4'h0, 8'h00, 0, 0, 0, 6);

        // randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            bit [3:0] op;
            op = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 7)) : 4'($urandom_range(0, 15));
            cyc(($urandom_range(0, 79) != 0), ($urandom_range(0, 4) != 0),
                8'($urandom), 8'($urandom), op, 8'($urandom),
                1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), 7);
        end

        @(posedge i_Clk);
        @(posedge i_Clk);
        if (sbq.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain got %0d pending required 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
